// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state codes and timeout defaults for the memory-game control unit.
// The state codes double as the debug display values.
package unidade_controle_jogo_pkg;

   localparam int unsigned TIMEOUT_CICLOS_PADRAO = 3000;
   localparam int unsigned LARGURA_T_PADRAO      = 12;

   typedef enum logic [3:0] {
      INICIAL      = 4'b0000,
      PREPARACAO   = 4'b0001,
      ESPERA_JOGADA = 4'b0010,
      REGISTRA     = 4'b0100,
      COMPARACAO   = 4'b0101,
      PROXIMO      = 4'b0110,
      FIM_ACERTOU  = 4'b1010,
      FIM_ERROU    = 4'b1110,
      FIM_TIMEOUT  = 4'b1101
   } estado_t;

   function automatic logic estado_final(input estado_t e);
      return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
   endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control-unit <-> datapath/top signals; slave is the control unit, master drives its inputs.
interface unidade_controle_jogo_if;
   logic       iniciar;
   logic       jogada;
   logic       igual;
   logic       fimC;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       acertou;
   logic       errou;
   logic       pronto;
   logic       db_timeout;
   logic       db_meio;
   logic [3:0] db_estado;

   modport master (
      output iniciar, jogada, igual, fimC,
      input  zeraC, contaC, zeraR, registraR, acertou, errou, pronto,
             db_timeout, db_meio, db_estado
   );

   modport slave (
      input  iniciar, jogada, igual, fimC,
      output zeraC, contaC, zeraR, registraR, acertou, errou, pronto,
             db_timeout, db_meio, db_estado
   );
endinterface

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Inactivity counter: clears on zera_i, counts on conta_i, saturates at CICLOS-1 (fim_o).
// meio_o flags that at least half of the budget has elapsed.
module contador_timeout #(
   parameter int unsigned CICLOS  = 3000,
   parameter int unsigned LARGURA = 12
) (
   input  logic clock,
   input  logic reset,
   input  logic zera_i,
   input  logic conta_i,
   output logic fim_o,
   output logic meio_o
);

   localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(CICLOS - 1);
   localparam logic [LARGURA-1:0] METADE = LARGURA'(CICLOS / 2);

   logic [LARGURA-1:0] contagem_q;
   logic [LARGURA-1:0] contagem_d;

   assign fim_o  = (contagem_q == ULTIMO);
   assign meio_o = (contagem_q >= METADE);

   always_comb begin
      contagem_d = contagem_q;
      if (zera_i) begin
         contagem_d = '0;
      end else if (conta_i && !fim_o) begin
         contagem_d = contagem_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contagem_q <= '0;
      end else begin
         contagem_q <= contagem_d;
      end
   end

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game: sequences datapath enables and round result.
// Outputs are registered alongside the state, so they depend on no input combinationally.
module unidade_controle_jogo
   import unidade_controle_jogo_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int unsigned LARGURA_T      = LARGURA_T_PADRAO
) (
   input  logic                    clock,
   input  logic                    reset,
   unidade_controle_jogo_if.slave  jogo
);

   estado_t estado_q;
   estado_t estado_d;

   logic zerac_q, contac_q, zerar_q, registrar_q;
   logic acertou_q, errou_q, pronto_q, timeout_q;
   logic tmo_fim, tmo_meio;

   contador_timeout #(
      .CICLOS  (TIMEOUT_CICLOS),
      .LARGURA (LARGURA_T)
   ) u_contador_timeout (
      .clock   (clock),
      .reset   (reset),
      .zera_i  ((estado_q == PREPARACAO) || (estado_q == PROXIMO)),
      .conta_i (estado_q == ESPERA_JOGADA),
      .fim_o   (tmo_fim),
      .meio_o  (tmo_meio)
   );

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:       if (jogo.iniciar) estado_d = PREPARACAO;
         PREPARACAO:    estado_d = ESPERA_JOGADA;
         // A play landing on the last allowed cycle still counts.
         ESPERA_JOGADA: begin
            if (jogo.jogada)  estado_d = REGISTRA;
            else if (tmo_fim) estado_d = FIM_TIMEOUT;
         end
         REGISTRA:      estado_d = COMPARACAO;
         COMPARACAO: begin
            if (!jogo.igual)    estado_d = FIM_ERROU;
            else if (jogo.fimC) estado_d = FIM_ACERTOU;
            else                estado_d = PROXIMO;
         end
         PROXIMO:       estado_d = ESPERA_JOGADA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (jogo.iniciar) estado_d = PREPARACAO;
         default:       estado_d = INICIAL;
      endcase
   end

   // Outputs are decoded from the next state so they line up with estado_q.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= INICIAL;
         zerac_q     <= 1'b0;
         contac_q    <= 1'b0;
         zerar_q     <= 1'b0;
         registrar_q <= 1'b0;
         acertou_q   <= 1'b0;
         errou_q     <= 1'b0;
         pronto_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         zerac_q     <= (estado_d == PREPARACAO);
         contac_q    <= (estado_d == PROXIMO);
         zerar_q     <= (estado_d == PREPARACAO);
         registrar_q <= (estado_d == REGISTRA);
         acertou_q   <= (estado_d == FIM_ACERTOU);
         errou_q     <= (estado_d == FIM_ERROU) || (estado_d == FIM_TIMEOUT);
         pronto_q    <= estado_final(estado_d);
         timeout_q   <= (estado_d == FIM_TIMEOUT);
      end
   end

   assign jogo.zeraC      = zerac_q;
   assign jogo.contaC     = contac_q;
   assign jogo.zeraR      = zerar_q;
   assign jogo.registraR  = registrar_q;
   assign jogo.acertou    = acertou_q;
   assign jogo.errou      = errou_q;
   assign jogo.pronto     = pronto_q;
   assign jogo.db_timeout = timeout_q;
   assign jogo.db_meio    = (estado_q == ESPERA_JOGADA) && tmo_meio;
   assign jogo.db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed vector table plus hand-written timeout/reset sequences for unidade_controle_jogo.
module tb_unidade_controle_jogo;

   localparam logic [3:0] S_INI = 4'b0000;
   localparam logic [3:0] S_PRE = 4'b0001;
   localparam logic [3:0] S_ESP = 4'b0010;
   localparam logic [3:0] S_REG = 4'b0100;
   localparam logic [3:0] S_CMP = 4'b0101;
   localparam logic [3:0] S_PRX = 4'b0110;
   localparam logic [3:0] S_ACE = 4'b1010;
   localparam logic [3:0] S_ERR = 4'b1110;
   localparam logic [3:0] S_TMO = 4'b1101;

   // {zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout, db_meio}
   localparam logic [8:0] O_NONE = 9'b000000000;
   localparam logic [8:0] O_ZC   = 9'b100000000;
   localparam logic [8:0] O_CC   = 9'b010000000;
   localparam logic [8:0] O_ZR   = 9'b001000000;
   localparam logic [8:0] O_RR   = 9'b000100000;
   localparam logic [8:0] O_AC   = 9'b000010000;
   localparam logic [8:0] O_ER   = 9'b000001000;
   localparam logic [8:0] O_PR   = 9'b000000100;
   localparam logic [8:0] O_TO   = 9'b000000010;
   localparam logic [8:0] O_ME   = 9'b000000001;

   typedef struct {
      logic       iniciar;
      logic       jogada;
      logic       igual;
      logic       fimC;
      logic [3:0] estado;
      logic [8:0] saida;
      string      nome;
   } vetor_t;

   logic clock;
   logic reset;
   unidade_controle_jogo_if bus ();

   unidade_controle_jogo dut (
      .clock (clock),
      .reset (reset),
      .jogo  (bus.slave)
   );

   logic [8:0] saidas;
   assign saidas = {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR, bus.acertou,
                    bus.errou, bus.pronto, bus.db_timeout, bus.db_meio};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int     n_vet;
   int     n_erro;
   vetor_t tab[$];

   task automatic add(input logic ini, input logic jog, input logic ig, input logic fc,
                      input logic [3:0] e, input logic [8:0] s, input string n);
      vetor_t v;
      v.iniciar = ini; v.jogada = jog; v.igual = ig; v.fimC = fc;
      v.estado = e; v.saida = s; v.nome = n;
      tab.push_back(v);
   endtask

   task automatic checar(input string nome, input logic [3:0] e, input logic [8:0] s);
      n_vet++;
      if (bus.db_estado !== e || saidas !== s) begin
         n_erro++;
         $display("FAIL %s: got estado=%b out=%b, expected estado=%b out=%b",
                  nome, bus.db_estado, saidas, e, s);
      end
   endtask

   task automatic checar_int(input string nome, input int got, input int exp);
      n_vet++;
      if (got != exp) begin
         n_erro++;
         $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic jogar(input logic ig, input logic fc);
      bus.jogada = 1'b0; bus.igual = ig; bus.fimC = fc;
   endtask

   initial begin
      int meio_at;
      int sai_at;
      n_vet = 0;
      n_erro = 0;
      reset = 1'b1;
      bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.igual = 1'b0; bus.fimC = 1'b0;

      // Idle, start with iniciar held, three good plays, a winning fourth.
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, S_INI, O_NONE, "idle");
      add(1, 0, 0, 0, S_PRE, O_ZC | O_ZR, "start_prep");
      for (int i = 0; i < 4; i++) add(1, 0, 0, 0, S_ESP, O_NONE, "start_held");
      add(0, 0, 0, 0, S_ESP, O_NONE, "start_wait");
      for (int p = 0; p < 3; p++) begin
         add(0, 1, 1, 0, S_REG, O_RR, "play_reg");
         add(0, 0, 0, 1, S_CMP, O_NONE, "play_cmp");
         add(0, 0, 1, 0, S_PRX, O_CC, "play_next");
         add(0, 1, 1, 0, S_ESP, O_NONE, "play_back");
      end
      add(0, 1, 1, 1, S_REG, O_RR, "last_reg");
      add(0, 0, 1, 1, S_CMP, O_NONE, "last_cmp");
      add(0, 0, 1, 1, S_ACE, O_AC | O_PR, "win");
      add(0, 1, 0, 0, S_ACE, O_AC | O_PR, "win_hold");
      // Restart, then a wrong play.
      add(1, 0, 0, 0, S_PRE, O_ZC | O_ZR, "restart_prep");
      add(1, 0, 0, 0, S_ESP, O_NONE, "restart_wait");
      add(1, 0, 0, 0, S_ESP, O_NONE, "iniciar_midround");
      add(0, 1, 0, 0, S_REG, O_RR, "wrong_reg");
      add(0, 0, 1, 1, S_CMP, O_NONE, "wrong_cmp");
      add(0, 0, 0, 1, S_ERR, O_ER | O_PR, "lose");
      add(0, 0, 0, 0, S_ERR, O_ER | O_PR, "lose_hold");
      add(1, 0, 0, 0, S_PRE, O_ZC | O_ZR, "to_prep");
      add(0, 0, 0, 0, S_ESP, O_NONE, "to_wait");

      #12;
      checar("in_reset", S_INI, O_NONE);
      @(negedge clock);
      reset = 1'b0;

      foreach (tab[i]) begin
         bus.iniciar = tab[i].iniciar;
         bus.jogada  = tab[i].jogada;
         bus.igual   = tab[i].igual;
         bus.fimC    = tab[i].fimC;
         step();
         checar(tab[i].nome, tab[i].estado, tab[i].saida);
      end
      bus.iniciar = 1'b0; bus.jogada = 1'b0;

      // Timeout: now in the first cycle of espera_jogada.
      meio_at = 0;
      sai_at = 0;
      for (int c = 1; c <= 3500; c++) begin
         if (meio_at == 0 && bus.db_meio) meio_at = c;
         if (bus.db_estado != S_ESP) begin
            sai_at = c;
            break;
         end
         step();
      end
      checar_int("meio_cycle", meio_at, 1501);
      checar_int("timeout_cycle", sai_at, 3001);
      checar("timeout_state", S_TMO, O_ER | O_PR | O_TO);
      step();
      checar("timeout_hold", S_TMO, O_ER | O_PR | O_TO);

      // Play on the last allowed cycle wins over the timeout.
      bus.iniciar = 1'b1; step(); bus.iniciar = 1'b0;
      checar("tmo_restart", S_PRE, O_ZC | O_ZR);
      step();
      checar("tmo_reentry", S_ESP, O_NONE);
      repeat (2999) step();
      checar("cycle_3000", S_ESP, O_ME);
      bus.jogada = 1'b1; step(); jogar(1'b1, 1'b0);
      checar("late_play", S_REG, O_RR);
      step();
      checar("late_cmp", S_CMP, O_NONE);
      step();
      checar("late_next", S_PRX, O_CC);
      step();
      checar("late_back", S_ESP, O_NONE);
      step();
      checar("late_cleared", S_ESP, O_NONE);

      // Asynchronous reset while in comparacao.
      bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
      step();
      checar("pre_reset_cmp", S_CMP, O_NONE);
      #2 reset = 1'b1;
      #1;
      checar("async_reset", S_INI, O_NONE);
      step();
      checar("reset_held", S_INI, O_NONE);
      @(negedge clock);
      reset = 1'b0;
      step();
      checar("after_reset", S_INI, O_NONE);

      // Reach fim_timeout again and restart: counter must be cleared.
      bus.iniciar = 1'b1; step(); bus.iniciar = 1'b0;
      step();
      checar("run2_wait", S_ESP, O_NONE);
      repeat (3000) step();
      checar("run2_timeout", S_TMO, O_ER | O_PR | O_TO);
      bus.iniciar = 1'b1; step(); bus.iniciar = 1'b0;
      checar("run2_restart", S_PRE, O_ZC | O_ZR);
      step();
      checar("run2_reentry", S_ESP, O_NONE);
      repeat (1499) step();
      checar("run2_cycle1500", S_ESP, O_NONE);
      step();
      checar("run2_cycle1501", S_ESP, O_ME);

      $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
      $finish;
   end

endmodule
